// File: rtl/crossbar_tick_gen.sv
// crossbar_tick_gen: multi-channel periodic tick generator pacing the
// crossbar array accesses of each PIM tile. Every channel has its own
// divisor, pulse width, phase offset and continuous/burst mode. Settings are
// written into a shadow set and copied to the working set only at a period
// boundary, on sync/enable, or while the channel is disabled, so a change
// never produces a shortened or merged tick.
module crossbar_tick_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 10
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                              cfg_div,
  input  logic [CNT_W-1:0]                              cfg_width,
  input  logic [CNT_W-1:0]                              cfg_phase,
  input  logic                                          cfg_mode,
  input  logic [CNT_W-1:0]                              cfg_burst,
  input  logic [NUM_CH-1:0]                             ch_en,
  input  logic                                          sync,
  output logic [NUM_CH-1:0]                             tick,
  output logic [NUM_CH-1:0]                             done,
  output logic [NUM_CH-1:0]                             active
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] wr_div;
  logic [CNT_W-1:0] wr_width;
  logic [CNT_W-1:0] wr_phase;
  logic [CNT_W-1:0] wr_burst;

  // Clamp the incoming write fields once; all channels share the result.
  always_comb begin
    wr_div   = (cfg_div < TWO) ? TWO : cfg_div;
    wr_width = cfg_width;
    if (cfg_width == '0) begin
      wr_width = ONE;
    end else if (cfg_width > wr_div - ONE) begin
      wr_width = wr_div - ONE;
    end
    wr_phase = (cfg_phase > wr_div - ONE) ? (wr_div - ONE) : cfg_phase;
    wr_burst = (cfg_burst == '0) ? ONE : cfg_burst;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] sh_div, sh_width, sh_phase, sh_burst;
    logic             sh_mode;
    logic [CNT_W-1:0] div_q, width_q, phase_q, burst_q;
    logic             mode_q;
    logic [CNT_W-1:0] nx_div, nx_width, nx_phase, nx_burst;
    logic             nx_mode;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] bcnt;
    logic             en_d;
    logic             tick_q;
    logic             done_q;
    logic             active_q;
    logic             wr_hit;
    logic             load;
    logic             at_wrap;
    logic             run_tick;
    logic             finish;
    logic             copy;

    // Shadow values as they will be after this edge, so a write landing on a
    // wrap, enable or sync edge is already the one that gets copied.
    always_comb begin
      wr_hit   = cfg_we && (cfg_ch == CH_W'(g));
      nx_div   = wr_hit ? wr_div   : sh_div;
      nx_width = wr_hit ? wr_width : sh_width;
      nx_phase = wr_hit ? wr_phase : sh_phase;
      nx_mode  = wr_hit ? cfg_mode : sh_mode;
      nx_burst = wr_hit ? wr_burst : sh_burst;
      load     = ch_en[g] && (!en_d || sync);
      at_wrap  = active_q && (cnt >= div_q - ONE);
      run_tick = active_q && (cnt >= div_q - width_q);
      finish   = active_q && mode_q && tick_q && !run_tick && (bcnt == burst_q);
      copy     = !ch_en[g] || load || at_wrap;
    end

    // Shadow register set, written by the configuration port.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh_div   <= DIV_RST;
        sh_width <= ONE;
        sh_phase <= '0;
        sh_mode  <= 1'b0;
        sh_burst <= ONE;
      end else if (wr_hit) begin
        sh_div   <= wr_div;
        sh_width <= wr_width;
        sh_phase <= wr_phase;
        sh_mode  <= cfg_mode;
        sh_burst <= wr_burst;
      end
    end

    // Working register set, refreshed only at safe points.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        div_q   <= DIV_RST;
        width_q <= ONE;
        phase_q <= '0;
        mode_q  <= 1'b0;
        burst_q <= ONE;
      end else if (copy) begin
        div_q   <= nx_div;
        width_q <= nx_width;
        phase_q <= nx_phase;
        mode_q  <= nx_mode;
        burst_q <= nx_burst;
      end
    end

    // Period counter, burst counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt      <= '0;
        bcnt     <= '0;
        en_d     <= 1'b0;
        tick_q   <= 1'b0;
        done_q   <= 1'b0;
        active_q <= 1'b0;
      end else begin
        en_d   <= ch_en[g];
        done_q <= 1'b0;
        if (!ch_en[g]) begin
          active_q <= 1'b0;
          tick_q   <= 1'b0;
        end else if (load) begin
          cnt      <= nx_phase;
          bcnt     <= '0;
          active_q <= 1'b1;
          tick_q   <= 1'b0;
        end else if (active_q) begin
          tick_q <= run_tick;
          if (run_tick && !tick_q) begin
            bcnt <= bcnt + ONE;
          end
          if (finish) begin
            active_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            cnt <= at_wrap ? '0 : cnt + ONE;
          end
        end
      end
    end

    assign tick[g]   = tick_q;
    assign done[g]   = done_q;
    assign active[g] = active_q;
  end

endmodule

// File: tb/tb_crossbar_tick_gen.sv
// Bench for crossbar_tick_gen: clamping table, hand-written multi-cycle
// sequences, and a randomized run against a period-queue reference model.
module tb_crossbar_tick_gen;
  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0, cfg_width = '0, cfg_phase = '0, cfg_burst = '0;
  logic       cfg_mode = 1'b0;
  logic [3:0] ch_en = '0;
  logic       sync = 1'b0;
  logic [3:0] tick, done, active;

  logic       cfg_we5 = 1'b0;
  logic [2:0] cfg_ch5 = '0;
  logic [4:0] ch_en5 = '0;
  logic [4:0] tick5, done5, active5;

  crossbar_tick_gen u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_width(cfg_width), .cfg_phase(cfg_phase),
    .cfg_mode(cfg_mode), .cfg_burst(cfg_burst), .ch_en(ch_en), .sync(sync),
    .tick(tick), .done(done), .active(active)
  );

  crossbar_tick_gen #(.NUM_CH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we5), .cfg_ch(cfg_ch5),
    .cfg_div(cfg_div), .cfg_width(cfg_width), .cfg_phase(cfg_phase),
    .cfg_mode(cfg_mode), .cfg_burst(cfg_burst), .ch_en(ch_en5), .sync(sync),
    .tick(tick5), .done(done5), .active(active5)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] others_seen;

  typedef struct {
    int div, wid, ph;
    int e_first, e_wid, e_per;
  } vec_t;
  vec_t tbl[8];

  // reference model state: settings as plain ints, future tick values of the
  // current period held in a queue
  int m_sdiv[NCH], m_swid[NCH], m_sph[NCH], m_smode[NCH], m_sbur[NCH];
  int m_div[NCH], m_wid[NCH], m_ph[NCH], m_mode[NCH], m_bur[NCH];
  int m_rises[NCH];
  bit m_run[NCH], m_pen[NCH], m_tick[NCH], m_done[NCH];
  bit m_q[NCH][$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ch_en = '0; ch_en5 = '0; cfg_we = 1'b0; cfg_we5 = 1'b0; sync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_cfg(input int ch, input int div, input int wid, input int ph,
                           input int mode, input int bur);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_div = 8'(div); cfg_width = 8'(wid);
    cfg_phase = 8'(ph); cfg_mode = mode[0]; cfg_burst = 8'(bur);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // edges until tick[ch] next rises (-1 on timeout); hi = high samples seen
  // before that rise, counting the starting sample
  task automatic wait_rise(input int ch, output int n, output int hi);
    logic prev;
    prev = tick[ch];
    n = -1;
    hi = 0;
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk); #1;
      others_seen |= tick & ~(4'b0001 << ch);
      if (prev) hi++;
      if (tick[ch] && !prev) begin
        n = k;
        return;
      end
      prev = tick[ch];
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < NCH; i++) begin
      m_sdiv[i] = 10; m_swid[i] = 1; m_sph[i] = 0; m_smode[i] = 0; m_sbur[i] = 1;
      m_div[i] = 10;  m_wid[i] = 1;  m_ph[i] = 0;  m_mode[i] = 0;  m_bur[i] = 1;
      m_rises[i] = 0; m_run[i] = 0; m_pen[i] = 0; m_tick[i] = 0; m_done[i] = 0;
      m_q[i].delete();
    end
  endtask

  task automatic model_copy(input int i);
    m_div[i] = m_sdiv[i]; m_wid[i] = m_swid[i]; m_ph[i] = m_sph[i];
    m_mode[i] = m_smode[i]; m_bur[i] = m_sbur[i];
  endtask

  task automatic model_gen(input int i, input int start);
    for (int p = start; p < m_div[i]; p++) m_q[i].push_back(p >= m_div[i] - m_wid[i]);
  endtask

  // one clock edge of the reference model, using the inputs held before it
  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      bit raw;
      int d;
      if (cfg_we && int'(cfg_ch) == i) begin
        d = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
        m_sdiv[i]  = d;
        m_swid[i]  = (cfg_width == 0) ? 1 : ((int'(cfg_width) > d - 1) ? d - 1 : int'(cfg_width));
        m_sph[i]   = (int'(cfg_phase) > d - 1) ? d - 1 : int'(cfg_phase);
        m_smode[i] = int'(cfg_mode);
        m_sbur[i]  = (cfg_burst == 0) ? 1 : int'(cfg_burst);
      end
      m_done[i] = 0;
      if (!ch_en[i]) begin
        m_run[i] = 0; m_tick[i] = 0; m_q[i].delete(); model_copy(i);
      end else if (!m_pen[i] || sync) begin
        model_copy(i);
        m_run[i] = 1; m_rises[i] = 0; m_tick[i] = 0; m_q[i].delete();
        model_gen(i, m_ph[i]);
      end else if (m_run[i]) begin
        raw = m_q[i].pop_front();
        if (m_mode[i] != 0 && m_tick[i] && !raw && m_rises[i] == m_bur[i]) begin
          m_run[i] = 0; m_done[i] = 1; m_tick[i] = 0;
        end else begin
          if (raw && !m_tick[i]) m_rises[i] = (m_rises[i] + 1) % 256;
          m_tick[i] = raw;
        end
        if (m_q[i].size() == 0) begin
          model_copy(i);
          if (m_run[i]) model_gen(i, 0);
        end
      end else begin
        m_tick[i] = 0;
      end
      m_pen[i] = ch_en[i];
    end
  endtask

  initial begin
    int n1, n2, n3, h, rises, dones, done_at, bad;
    logic prev;
    logic [3:0] e_t, e_d, e_a;

    tbl[0] = '{10, 1,   0, 10, 1, 10};
    tbl[1] = '{ 4, 2,   0,  3, 2,  4};
    tbl[2] = '{ 1, 1,   0,  2, 1,  2};
    tbl[3] = '{ 0, 0,   0,  2, 1,  2};
    tbl[4] = '{10, 0,   0, 10, 1, 10};
    tbl[5] = '{ 6, 9,   0,  2, 5,  6};
    tbl[6] = '{ 8, 3, 200,  1, 3,  8};
    tbl[7] = '{ 5, 2,   1,  3, 2,  5};

    // reset state
    #2 rst_n = 1'b0;
    #10;
    check("reset tick", 32'(tick), 0);
    check("reset done", 32'(done), 0);
    check("reset active", 32'(active), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // clamping / timing table on ch0
    others_seen = '0;
    for (int e = 0; e < 8; e++) begin
      write_cfg(0, tbl[e].div, tbl[e].wid, tbl[e].ph, 0, 1);
      ch_en = 4'b0001;
      @(posedge clk); #1;
      wait_rise(0, n1, h);
      check($sformatf("tbl%0d first", e), 32'(n1), 32'(tbl[e].e_first));
      wait_rise(0, n2, h);
      wait_rise(0, n3, h);
      check($sformatf("tbl%0d period", e), 32'(n3), 32'(tbl[e].e_per));
      check($sformatf("tbl%0d width", e), 32'(h), 32'(tbl[e].e_wid));
      @(negedge clk); ch_en = '0;
      @(negedge clk);
    end
    check("idle channels", 32'(others_seen), 0);

    // divisor change mid-period takes effect after the running period
    write_cfg(0, 10, 1, 0, 0, 1);
    ch_en = 4'b0001;
    @(posedge clk); #1;
    wait_rise(0, n1, h);
    check("midchg first", 32'(n1), 10);
    write_cfg(0, 6, 1, 0, 0, 1);
    wait_rise(0, n1, h);
    check("midchg old period", 32'(n1), 9);
    wait_rise(0, n2, h);
    check("midchg new period", 32'(n2), 6);
    check("midchg width", 32'(h), 1);
    wait_rise(0, n3, h);
    check("midchg new period2", 32'(n3), 6);
    @(negedge clk); ch_en = '0;

    // burst mode, run twice
    write_cfg(2, 5, 1, 0, 1, 3);
    for (int r = 0; r < 2; r++) begin
      ch_en = 4'b0100;
      @(posedge clk); #1;
      rises = 0; dones = 0; done_at = -1; prev = 1'b0;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk); #1;
        if (tick[2] && !prev) rises++;
        if (done[2]) begin
          dones++;
          if (done_at < 0) done_at = k;
        end
        prev = tick[2];
      end
      check($sformatf("burst%0d ticks", r), 32'(rises), 3);
      check($sformatf("burst%0d dones", r), 32'(dones), 1);
      check($sformatf("burst%0d done cycle", r), 32'(done_at), 16);
      check($sformatf("burst%0d active end", r), 32'(active[2]), 0);
      @(negedge clk); ch_en = '0;
      @(negedge clk);
      @(negedge clk);
    end

    // staggered phases, last write coincides with sync
    do_reset();
    ch_en = 4'hF;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) write_cfg(i, 8, 1, 2 * i, 0, 1);
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd8; cfg_width = 8'd1;
    cfg_phase = 8'd6; cfg_mode = 1'b0; cfg_burst = 8'd1; sync = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; sync = 1'b0;
    check("sync tick clear", 32'(tick), 0);
    n1 = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) e_t[i] = ((2 * i + k - 1) % 8) == 7;
      check($sformatf("stagger k=%0d", k), 32'(tick), 32'(e_t));
      if (tick[0]) n1++;
    end
    check("stagger ch0 ticks", 32'(n1 >= 12), 1);

    // reset in the middle of a burst
    do_reset();
    write_cfg(2, 5, 1, 0, 1, 3);
    ch_en = 4'b0100;
    @(posedge clk); #1;
    wait_rise(2, n1, h);
    check("midrst first tick", 32'(n1), 5);
    #2 rst_n = 1'b0;
    #1;
    check("midrst tick", 32'(tick), 0);
    check("midrst active", 32'(active), 0);
    check("midrst done", 32'(done), 0);
    ch_en = '0;
    bad = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done != 0 || tick != 0 || active != 0) bad++;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done != 0 || tick != 0 || active != 0) bad++;
    end
    check("midrst quiet after", 32'(bad), 0);

    // out-of-range channel on a 5-channel instance is ignored
    do_reset();
    @(negedge clk);
    cfg_we5 = 1'b1; cfg_ch5 = 3'd7; cfg_div = 8'd3; cfg_width = 8'd1;
    cfg_phase = 8'd0; cfg_mode = 1'b0; cfg_burst = 8'd1;
    @(negedge clk);
    cfg_we5 = 1'b0; ch_en5 = 5'h1F;
    @(posedge clk); #1;
    n1 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (tick5 != 0) begin
        n1 = k;
        break;
      end
    end
    check("ch7 ignored first", 32'(n1), 10);
    check("ch7 ignored all", 32'(tick5), 32'h1F);
    ch_en5 = '0;

    // randomized run against the reference model
    do_reset();
    model_init();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_div = 8'($urandom_range(0, 12));
      cfg_width = 8'($urandom_range(0, 13));
      cfg_phase = 8'($urandom_range(0, 15));
      cfg_mode = 1'($urandom_range(0, 1));
      cfg_burst = 8'($urandom_range(0, 4));
      sync = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 59) == 0) ch_en[i] = ~ch_en[i];
      @(posedge clk);
      model_step();
      #1;
      for (int i = 0; i < NCH; i++) begin
        e_t[i] = m_tick[i]; e_d[i] = m_done[i]; e_a[i] = m_run[i];
      end
      check($sformatf("rand tick c=%0d", c), 32'(tick), 32'(e_t));
      check($sformatf("rand done c=%0d", c), 32'(done), 32'(e_d));
      check($sformatf("rand active c=%0d", c), 32'(active), 32'(e_a));
    end
    @(negedge clk);
    cfg_we = 1'b0; sync = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
